mem_stage: RTL and testbench

//  MEM stage of the 8-bit pipeline; consumes the MEM_* bundle from the EX/MEM register.

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_wb_reg.sv | 46 ++++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, the access timeout
// and the memory-handshake FSM state encoding.
package mem_stage_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_RADDR_W = 2;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A stalled cycle becomes a bubble: the write
// enable and halt pulse are cleared while rd/data simply hold.
module mem_wb_reg #(
    parameter int DATA_W  = 8,
    parameter int RADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bubble_i,
    input  logic               reg_write_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0]  write_data_i,
    input  logic               halt_i,
    output logic               reg_write_o,
    output logic [RADDR_W-1:0] rd_o,
    output logic [DATA_W-1:0]  write_data_o,
    output logic               halt_o
);

    logic               reg_write_q;
    logic [RADDR_W-1:0] rd_q;
    logic [DATA_W-1:0]  write_data_q;
    logic               halt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            write_data_q <= '0;
            halt_q       <= 1'b0;
        end else begin
            reg_write_q <= reg_write_i & ~bubble_i;
            halt_q      <= halt_i & ~bubble_i;
            if (!bubble_i) begin
                rd_q         <= rd_i;
                write_data_q <= write_data_i;
            end
        end
    end

    assign reg_write_o  = reg_write_q;
    assign rd_o         = rd_q;
    assign write_data_o = write_data_q;
    assign halt_o       = halt_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 8-bit pipeline: data-memory req/ack handshake with a
// bounded wait, jump/branch resolution, halt latching and the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  MEM_alu_result,
    input  logic               MEM_zero_flag,
    input  logic               MEM_neg_flag,
    input  logic [DATA_W-1:0]  MEM_reg_data_2,
    input  logic [RADDR_W-1:0] MEM_rd,
    input  logic [ADDR_W-1:0]  MEM_branch_target,
    input  logic               MEM_reg_write,
    input  logic               MEM_mem_read,
    input  logic               MEM_mem_write,
    input  logic               MEM_mem_to_reg,
    input  logic               MEM_jump,
    input  logic               MEM_branch_zero,
    input  logic               MEM_branch_neg,
    input  logic               MEM_halt,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               stall,
    output logic               pc_src,
    output logic [ADDR_W-1:0]  pc_target,
    output logic [DATA_W-1:0]  WB_write_data,
    output logic [RADDR_W-1:0] WB_rd,
    output logic               WB_reg_write,
    output logic               WB_halt,
    output logic               halted,
    output logic               mem_error
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next;
    logic              halted_q, halted_d;
    logic              mem_error_q, mem_error_d;
    logic              access;
    logic              taken;
    logic              load_data;
    logic [DATA_W-1:0] wb_data;

    assign access    = MEM_mem_read | MEM_mem_write;
    assign taken     = MEM_jump | (MEM_branch_zero & MEM_zero_flag) | (MEM_branch_neg & MEM_neg_flag);
    // A simultaneous read+write is treated as a store, so it never loads.
    assign load_data = MEM_mem_to_reg & MEM_mem_read & ~MEM_mem_write;
    assign wb_data   = load_data ? dmem_rdata : MEM_alu_result;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            mem_error_q <= mem_error_d;
        end
    end

    // cnt_next is the number of un-acked request cycles including this one.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        halted_d    = halted_q;
        mem_error_d = mem_error_q;
        cnt_next    = ((state_q == WAIT) ? cnt_q : '0) + CNT_W'(1);
        case (state_q)
            IDLE, WAIT: begin
                if (dmem_req && !dmem_ack) begin
                    if (cnt_next >= CNT_W'(TIMEOUT)) begin
                        state_d     = ERROR;
                        cnt_d       = '0;
                        halted_d    = 1'b1;
                        mem_error_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = cnt_next;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        if (MEM_halt && !stall) begin
            halted_d = 1'b1;
        end
    end

    always_comb begin
        dmem_req = 1'b0;
        stall    = 1'b0;
        pc_src   = 1'b0;
        if (reset) begin
            dmem_req = access & ~halted_q & (state_q != ERROR);
            stall    = (dmem_req & ~dmem_ack) | halted_q;
            pc_src   = ~halted_q & taken;
        end
    end

    assign dmem_we    = MEM_mem_write;
    assign dmem_addr  = ADDR_W'(MEM_alu_result);
    assign dmem_wdata = MEM_reg_data_2;
    assign pc_target  = MEM_branch_target;
    assign halted     = halted_q;
    assign mem_error  = mem_error_q;

    mem_wb_reg #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_mem_wb_reg (
        .clk          (clk),
        .reset        (reset),
        .bubble_i     (stall),
        .reg_write_i  (MEM_reg_write),
        .rd_i         (MEM_rd),
        .write_data_i (wb_data),
        .halt_i       (MEM_halt),
        .reg_write_o  (WB_reg_write),
        .rd_o         (WB_rd),
        .write_data_o (WB_write_data),
        .halt_o       (WB_halt)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a driver issues instructions and
// pushes expected write-backs; a monitor pops them whenever WB_reg_write fires.
module tb_mem_stage;

    typedef struct {
        logic [7:0] alu;
        logic       zero;
        logic       neg;
        logic [7:0] wdata;
        logic [1:0] rd;
        logic [7:0] target;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       jump;
        logic       bz;
        logic       bn;
    } instr_t;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
    } wb_t;

    logic       clk;
    logic       reset;
    logic [7:0] MEM_alu_result;
    logic       MEM_zero_flag;
    logic       MEM_neg_flag;
    logic [7:0] MEM_reg_data_2;
    logic [1:0] MEM_rd;
    logic [7:0] MEM_branch_target;
    logic       MEM_reg_write;
    logic       MEM_mem_read;
    logic       MEM_mem_write;
    logic       MEM_mem_to_reg;
    logic       MEM_jump;
    logic       MEM_branch_zero;
    logic       MEM_branch_neg;
    logic       MEM_halt;
    logic       dmem_req;
    logic       dmem_we;
    logic [7:0] dmem_addr;
    logic [7:0] dmem_wdata;
    logic       dmem_ack;
    logic [7:0] dmem_rdata;
    logic       stall;
    logic       pc_src;
    logic [7:0] pc_target;
    logic [7:0] WB_write_data;
    logic [1:0] WB_rd;
    logic       WB_reg_write;
    logic       WB_halt;
    logic       halted;
    logic       mem_error;

    int  total = 0;
    int  bad   = 0;
    wb_t expQ[$];

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .MEM_alu_result    (MEM_alu_result),
        .MEM_zero_flag     (MEM_zero_flag),
        .MEM_neg_flag      (MEM_neg_flag),
        .MEM_reg_data_2    (MEM_reg_data_2),
        .MEM_rd            (MEM_rd),
        .MEM_branch_target (MEM_branch_target),
        .MEM_reg_write     (MEM_reg_write),
        .MEM_mem_read      (MEM_mem_read),
        .MEM_mem_write     (MEM_mem_write),
        .MEM_mem_to_reg    (MEM_mem_to_reg),
        .MEM_jump          (MEM_jump),
        .MEM_branch_zero   (MEM_branch_zero),
        .MEM_branch_neg    (MEM_branch_neg),
        .MEM_halt          (MEM_halt),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_ack          (dmem_ack),
        .dmem_rdata        (dmem_rdata),
        .stall             (stall),
        .pc_src            (pc_src),
        .pc_target         (pc_target),
        .WB_write_data     (WB_write_data),
        .WB_rd             (WB_rd),
        .WB_reg_write      (WB_reg_write),
        .WB_halt           (WB_halt),
        .halted            (halted),
        .mem_error         (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every retired register write must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && WB_reg_write === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL wb_unexpected: got write rd=%0h data=%0h expected none", WB_rd, WB_write_data);
            end else begin
                wb_t e;
                e = expQ.pop_front();
                checkOutput("wb_rd", 32'(WB_rd), 32'(e.rd));
                checkOutput("wb_data", 32'(WB_write_data), 32'(e.data));
            end
        end
    end

    task automatic clearInputs();
        MEM_alu_result    = 8'h00;
        MEM_zero_flag     = 1'b0;
        MEM_neg_flag      = 1'b0;
        MEM_reg_data_2    = 8'h00;
        MEM_rd            = 2'd0;
        MEM_branch_target = 8'h00;
        MEM_reg_write     = 1'b0;
        MEM_mem_read      = 1'b0;
        MEM_mem_write     = 1'b0;
        MEM_mem_to_reg    = 1'b0;
        MEM_jump          = 1'b0;
        MEM_branch_zero   = 1'b0;
        MEM_branch_neg    = 1'b0;
        MEM_halt          = 1'b0;
        dmem_ack          = 1'b0;
        dmem_rdata        = 8'h00;
    endtask

    task automatic driveInstr(input instr_t ins);
        MEM_alu_result    = ins.alu;
        MEM_zero_flag     = ins.zero;
        MEM_neg_flag      = ins.neg;
        MEM_reg_data_2    = ins.wdata;
        MEM_rd            = ins.rd;
        MEM_branch_target = ins.target;
        MEM_reg_write     = ins.regWrite;
        MEM_mem_read      = ins.memRead;
        MEM_mem_write     = ins.memWrite;
        MEM_mem_to_reg    = ins.memToReg;
        MEM_jump          = ins.jump;
        MEM_branch_zero   = ins.bz;
        MEM_branch_neg    = ins.bn;
        MEM_halt          = 1'b0;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that retires the instruction.
    task automatic applyStimulus(input instr_t ins, input int ackDelay, input logic [7:0] rdata, input logic strayAck);
        logic access;
        logic expPc;
        wb_t  e;
        access = ins.memRead | ins.memWrite;
        expPc  = ins.jump | (ins.bz & ins.zero) | (ins.bn & ins.neg);
        driveInstr(ins);
        dmem_ack   = 1'b0;
        dmem_rdata = rdata;
        if (access) begin
            for (int i = 0; i < ackDelay; i++) begin
                @(negedge clk);
                checkOutput("wait_stall", 32'(stall), 32'd1);
                checkOutput("wait_req", 32'(dmem_req), 32'd1);
                @(posedge clk);
                #1;
            end
            dmem_ack = 1'b1;
        end else begin
            dmem_ack = strayAck;
        end
        @(negedge clk);
        checkOutput("stall", 32'(stall), 32'd0);
        checkOutput("pc_src", 32'(pc_src), 32'(expPc));
        checkOutput("pc_target", 32'(pc_target), 32'(ins.target));
        checkOutput("req", 32'(dmem_req), 32'(access));
        if (access) begin
            checkOutput("we", 32'(dmem_we), 32'(ins.memWrite));
            checkOutput("addr", 32'(dmem_addr), 32'(ins.alu));
            checkOutput("wdata", 32'(dmem_wdata), 32'(ins.wdata));
        end
        if (ins.regWrite) begin
            e.rd   = ins.rd;
            e.data = (ins.memToReg && ins.memRead && !ins.memWrite) ? rdata : ins.alu;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
    endtask

    task automatic doReset(input int cycles);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic instr_t blankInstr();
        instr_t i;
        i.alu = 8'h00; i.zero = 1'b0; i.neg = 1'b0; i.wdata = 8'h00; i.rd = 2'd0;
        i.target = 8'h00; i.regWrite = 1'b0; i.memRead = 1'b0; i.memWrite = 1'b0;
        i.memToReg = 1'b0; i.jump = 1'b0; i.bz = 1'b0; i.bn = 1'b0;
        return i;
    endfunction

    initial begin
        instr_t ins;
        int     cnt;
        reset = 1'b0;
        clearInputs();
        // Reset with active-looking inputs: combinational outputs must stay low.
        MEM_mem_read = 1'b1;
        MEM_jump     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_pc_src", 32'(pc_src), 32'd0);
        checkOutput("rst_wb_we", 32'(WB_reg_write), 32'd0);
        checkOutput("rst_wb_halt", 32'(WB_halt), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_err", 32'(mem_error), 32'd0);
        @(posedge clk);
        #1;
        clearInputs();
        reset = 1'b1;

        // ALU op writes 3C to r2.
        ins = blankInstr(); ins.alu = 8'h3C; ins.rd = 2'd2; ins.regWrite = 1'b1;
        applyStimulus(ins, 0, 8'h00, 1'b0);
        // Load from 10, ack after 3 wait cycles, data A5.
        ins = blankInstr(); ins.alu = 8'h10; ins.rd = 2'd1; ins.regWrite = 1'b1;
        ins.memRead = 1'b1; ins.memToReg = 1'b1;
        applyStimulus(ins, 3, 8'hA5, 1'b0);
        // Store to 20 with same-cycle ack.
        ins = blankInstr(); ins.alu = 8'h20; ins.wdata = 8'h7E; ins.memWrite = 1'b1;
        applyStimulus(ins, 0, 8'h00, 1'b0);
        // Branch on negative, taken then not taken.
        ins = blankInstr(); ins.bn = 1'b1; ins.neg = 1'b1; ins.target = 8'h44;
        applyStimulus(ins, 0, 8'h00, 1'b0);
        ins.neg = 1'b0;
        applyStimulus(ins, 0, 8'h00, 1'b0);
        // Longest wait that still completes: TIMEOUT-1 un-acked cycles.
        ins = blankInstr(); ins.alu = 8'h55; ins.rd = 2'd3; ins.regWrite = 1'b1;
        ins.memRead = 1'b1; ins.memToReg = 1'b1;
        applyStimulus(ins, 14, 8'hC3, 1'b0);
        // Read+write together behaves as a store; data comes from the ALU.
        ins = blankInstr(); ins.alu = 8'h66; ins.wdata = 8'h99; ins.rd = 2'd0; ins.regWrite = 1'b1;
        ins.memRead = 1'b1; ins.memWrite = 1'b1; ins.memToReg = 1'b1;
        applyStimulus(ins, 1, 8'hEE, 1'b0);

        for (int n = 0; n < 200; n++) begin
            int sel;
            ins.alu      = 8'($urandom);
            ins.zero     = 1'($urandom);
            ins.neg      = 1'($urandom);
            ins.wdata    = 8'($urandom);
            ins.rd       = 2'($urandom);
            ins.target   = 8'($urandom);
            ins.regWrite = 1'($urandom);
            ins.memToReg = 1'($urandom);
            ins.jump     = ($urandom_range(0, 3) == 0);
            ins.bz       = 1'($urandom);
            ins.bn       = 1'($urandom);
            sel          = $urandom_range(0, 7);
            ins.memRead  = (sel == 1) || (sel == 2) || (sel == 3) || (sel == 5);
            ins.memWrite = (sel == 4) || (sel == 5);
            applyStimulus(ins, $urandom_range(0, 4), 8'($urandom), 1'($urandom));
        end

        // Halt retires: one WB_halt pulse, then everything is ignored.
        clearInputs();
        MEM_halt = 1'b1;
        @(posedge clk);
        #1;
        clearInputs();
        @(negedge clk);
        checkOutput("halt_pulse", 32'(WB_halt), 32'd1);
        checkOutput("halted_set", 32'(halted), 32'd1);
        checkOutput("halt_stall", 32'(stall), 32'd1);
        ins = blankInstr(); ins.alu = 8'h30; ins.rd = 2'd1; ins.regWrite = 1'b1;
        ins.memRead = 1'b1; ins.memToReg = 1'b1; ins.jump = 1'b1;
        @(posedge clk);
        #1;
        driveInstr(ins);
        @(negedge clk);
        checkOutput("halt_pulse_end", 32'(WB_halt), 32'd0);
        checkOutput("halted_no_req", 32'(dmem_req), 32'd0);
        checkOutput("halted_no_pc_src", 32'(pc_src), 32'd0);
        repeat (3) @(posedge clk);
        doReset(1);
        clearInputs();
        @(negedge clk);
        checkOutput("halt_cleared", 32'(halted), 32'd0);

        // Load with no ack: error after TIMEOUT stall cycles.
        @(posedge clk);
        #1;
        driveInstr(ins);
        MEM_jump = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_error === 1'b1) break;
            if (stall === 1'b1) cnt++;
            @(posedge clk);
        end
        checkOutput("timeout_err", 32'(mem_error), 32'd1);
        checkOutput("timeout_cycles", 32'(cnt), 32'd15);
        checkOutput("timeout_halted", 32'(halted), 32'd1);
        checkOutput("timeout_req", 32'(dmem_req), 32'd0);
        checkOutput("timeout_stall", 32'(stall), 32'd1);
        doReset(1);
        clearInputs();
        @(negedge clk);
        checkOutput("err_cleared", 32'(mem_error), 32'd0);
        checkOutput("err_halt_cleared", 32'(halted), 32'd0);

        // Reset in the middle of a wait abandons the access.
        @(posedge clk);
        #1;
        driveInstr(ins);
        MEM_jump = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_wait_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_wait_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        clearInputs();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_req", 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        ins = blankInstr(); ins.alu = 8'h77; ins.rd = 2'd2; ins.regWrite = 1'b1;
        ins.memRead = 1'b1; ins.memToReg = 1'b1;
        applyStimulus(ins, 2, 8'h5A, 1'b0);

        clearInputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
